// File: rtl/fir_out_pkg.sv
// Shared widths, limits and the shift/clamp helper for the FIR output stage.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package fir_out_pkg;

    localparam int DEF_IN_W   = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DROP_CNT_W = 16;
    // Working width for the shift/clamp arithmetic; must cover IN_W+1 bits.
    localparam int CALC_W     = 64;

    typedef logic signed [DEF_OUT_W-1:0] out_sample_t;

    localparam out_sample_t OUT_MAX = out_sample_t'({1'b0, {(DEF_OUT_W-1){1'b1}}});
    localparam out_sample_t OUT_MIN = out_sample_t'({1'b1, {(DEF_OUT_W-1){1'b0}}});

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] q;
    } rs_t;

    // Takes the already rounded (bias-added) sum, shifts it down arithmetically
    // and clamps it into a signed out_w-bit range, flagging when it clamped.
    function automatic rs_t round_sat(input logic signed [CALC_W-1:0] s,
                                      input int shift,
                                      input int out_w);
        rs_t                      r;
        logic signed [CALC_W-1:0] q;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        q     = s >>> shift;
        hi    = (CALC_W'(1) << (out_w - 1)) - CALC_W'(1);
        lo    = ~hi;
        r.sat = 1'b0;
        r.q   = q;
        if (q > hi) begin
            r.q   = hi;
            r.sat = 1'b1;
        end else if (q < lo) begin
            r.q   = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Show-ahead synchronous FIFO: head entry is always visible on dat_o.
// Latency: a push is visible on dat_o after the next clock edge (no fall-through).
// Backpressure: push refused when full unless a pop happens on the same edge.
module fir_out_fifo
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Empty FIFO presents zero so dout is 0 out of reset.
    assign dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset; the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// Round/scale/saturate FIR accumulator output, decimate, buffer in a FIFO; optional peak via FIR_OUT_PEAK_EN.
// Latency: din to dout is 3 cycles (bias add, shift/clamp/keep, FIFO write).
// Backpressure: no stall upstream; kept samples arriving at a full FIFO are dropped and counted.
module fir_output_stage
    import fir_out_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IN_W-1:0]               din,
    input  logic                          din_en,
    output logic [OUT_W-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          sat_flag,
    output logic [DROP_CNT_W-1:0]         drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          stat_clr,
    output logic [OUT_W-1:0]              peak_abs
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

    // Stage 1: sign-extended input plus rounding bias.
    logic signed [IN_W:0]     s1_d;
    logic signed [IN_W:0]     s1_q;
    logic                     s1_vld_q;

    // Stage 2: clamped sample, its saturation bit and the keep decision.
    logic signed [CALC_W-1:0] s1_ext;
    rs_t                      rs;
    logic                     rs_unused;
    logic [PH_W-1:0]          phase_d;
    logic [PH_W-1:0]          phase_q;
    logic                     s2_vld_q;
    logic [OUT_W-1:0]         s2_dat_q;
    logic                     s2_sat_q;

    // Stage 3: FIFO and status.
    logic                     pop_vld;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     drop_evt;
    logic                     sat_flag_q;
    logic [DROP_CNT_W-1:0]    drop_cnt_q;

    assign s1_d      = $signed({din[IN_W-1], din}) + RND;
    assign s1_ext    = CALC_W'(s1_q);
    assign rs        = round_sat(s1_ext, SHIFT, OUT_W);
    // Upper bits are a pure sign extension of the clamped value.
    assign rs_unused = ^rs.q[CALC_W-1:OUT_W];

    // Stage 1 register: valid follows din_en every cycle, data only loads on a sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= din_en;
            if (din_en) begin
                s1_q <= s1_d;
            end
        end
    end

    // Decimation phase advances only on real samples, so idle cycles hold it.
    always_comb begin
        phase_d = phase_q;
        if (s1_vld_q) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Stage 2 register: phase 0 samples are kept, the rest never reach the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            s2_sat_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            s2_vld_q <= s1_vld_q && (phase_q == '0);
            if (s1_vld_q) begin
                s2_dat_q <= rs.q[OUT_W-1:0];
                s2_sat_q <= rs.sat;
            end
        end
    end

    assign pop_vld  = dout_valid && dout_ready;
    // A pop on the same edge frees the slot, so only an unpopped full FIFO drops.
    assign drop_evt = s2_vld_q && fifo_full && !pop_vld;

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (s2_vld_q),
        .push_dat_i (s2_dat_q),
        .pop_i      (pop_vld),
        .dat_o      (dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign dout_valid = !fifo_empty;

    // Sticky saturation and saturating drop counter; a clear beats a same-cycle event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (stat_clr) begin
            sat_flag_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (s2_vld_q && s2_sat_q) begin
                sat_flag_q <= 1'b1;
            end
            if (drop_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign sat_flag = sat_flag_q;
    assign drop_cnt = drop_cnt_q;

`ifdef FIR_OUT_PEAK_EN
    localparam logic [OUT_W-1:0] MAG_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MAG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] mag;
    logic [OUT_W-1:0] peak_q;

    // Magnitude of the stage-2 sample; the most negative code folds to the max positive.
    always_comb begin
        mag = s2_dat_q;
        if (s2_dat_q == MAG_MIN) begin
            mag = MAG_MAX;
        end else if (s2_dat_q[OUT_W-1]) begin
            mag = (~s2_dat_q) + 1'b1;
        end
    end

    // Peak follows every kept sample, including ones the FIFO drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else if (stat_clr) begin
            peak_q <= '0;
        end else if (s2_vld_q && (mag > peak_q)) begin
            peak_q <= mag;
        end
    end

    assign peak_abs = peak_q;
`else
    assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_fir_output_stage.sv
// Randomized and directed bench for fir_output_stage against a queue-based reference model.
// Latency: model pushes each kept sample two edges after the edge that captured it.
// Backpressure: model FIFO holds FIFO_DEPTH entries; overflow increments the modelled drop count.
module tb_fir_output_stage;

    localparam int DECIM = 4;
    localparam int SHIFT = 15;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] din = '0;
    logic        din_en = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        sat_flag;
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_level;
    logic        stat_clr = 1'b0;
    logic [15:0] peak_abs;

    fir_output_stage #(
        .IN_W       (32),
        .OUT_W      (16),
        .SHIFT      (SHIFT),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_en     (din_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_flag   (sat_flag),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level),
        .stat_clr   (stat_clr),
        .peak_abs   (peak_abs)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples in flight, expected FIFO contents, status.
    typedef struct {
        bit          vld;
        logic [15:0] val;
        bit          sat;
    } ent_t;

    ent_t        m_last;
    ent_t        m_prev2;
    logic [15:0] m_q[$];
    bit          m_sat;
    int          m_drop;
    int          m_peak;
    int          m_cnt;
    logic [15:0] pops[$];

    task automatic model_reset();
        m_last  = '{vld: 1'b0, val: '0, sat: 1'b0};
        m_prev2 = '{vld: 1'b0, val: '0, sat: 1'b0};
        m_q.delete();
        m_sat  = 1'b0;
        m_drop = 0;
        m_peak = 0;
        m_cnt  = 0;
    endtask

    // Plain-arithmetic rounding, shift and clamp; keep every DECIM-th sample since reset.
    task automatic model_capture(input logic [31:0] d, output ent_t e);
        longint v;
        v = longint'($signed(d));
        v = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        e.sat = 1'b0;
        if (v > 32767) begin
            v = 32767;
            e.sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            e.sat = 1'b1;
        end
        e.val = v[15:0];
        e.vld = ((m_cnt % DECIM) == 0);
        m_cnt++;
    endtask

    task automatic model_edge(input bit en, input logic [31:0] d, input bit rdy, input bit clr);
        bit   pop;
        ent_t e;
        int   sv;
        int   mag;
        pop = (m_q.size() > 0) && rdy;
        if (pop) begin
            void'(m_q.pop_front());
        end
        if (m_prev2.vld) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_prev2.val);
            end else if (m_drop < 16'hFFFF) begin
                m_drop++;
            end
            if (m_prev2.sat) begin
                m_sat = 1'b1;
            end
            sv  = int'($signed(m_prev2.val));
            mag = (sv < 0) ? -sv : sv;
            if (mag > 32767) begin
                mag = 32767;
            end
            if (mag > m_peak) begin
                m_peak = mag;
            end
        end
        if (clr) begin
            m_sat  = 1'b0;
            m_drop = 0;
            m_peak = 0;
        end
        m_prev2 = m_last;
        if (en) begin
            model_capture(d, e);
        end else begin
            e = '{vld: 1'b0, val: '0, sat: 1'b0};
        end
        m_last = e;
    endtask

    task automatic check_all();
        chk("dout_valid", dout_valid, (m_q.size() > 0));
        chk("fifo_level", fifo_level, m_q.size());
        if (m_q.size() > 0) begin
            chk("dout", dout, m_q[0]);
        end else begin
            chk("dout_idle", dout, 0);
        end
        chk("sat_flag", sat_flag, m_sat);
        chk("drop_cnt", drop_cnt, m_drop);
`ifdef FIR_OUT_PEAK_EN
        chk("peak_abs", peak_abs, m_peak);
`else
        chk("peak_abs", peak_abs, 0);
`endif
    endtask

    // One clock: drive inputs, note any pop, advance DUT and model, compare #1 after the edge.
    task automatic step(input bit en, input logic [31:0] d, input bit rdy, input bit clr);
        din_en     = en;
        din        = d;
        dout_ready = rdy;
        stat_clr   = clr;
        if (dout_valid && rdy) begin
            pops.push_back(dout);
        end
        @(posedge clk);
        model_edge(en, d, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        din_en     = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        stat_clr   = 1'b0;
        reset_n    = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        pops.delete();
    endtask

    task automatic chk_pops(input string tag, input logic [15:0] exp[$]);
        chk({tag, "_npop"}, pops.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(tag, (i < pops.size()) ? pops[i] : 16'hDEAD, exp[i]);
        end
    endtask

    initial begin
        logic [31:0] dir_vals[5];
        logic [15:0] exp_q[$];

        // Reset state
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Rounding and saturation points, each followed by three discarded fillers
        dir_vals = '{32'h0000_4000, 32'h0000_3FFF, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("sat_before_clr", sat_flag, 1);
                step(1'b0, '0, 1'b1, 1'b1);
                chk("sat_after_clr", sat_flag, 0);
            end
            step(1'b1, dir_vals[i], 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) begin
                step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
            end
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("sat_min_no_sat", sat_flag, 0);
        exp_q = '{16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000};
        chk_pops("dir_pop", exp_q);

        // Ramp n<<15 with decimation by 4 and first-output latency
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step(1'b1, 32'(n) << 15, 1'b1, 1'b0);
            if (n == 1) chk("lat_not_yet", dout_valid, 0);
            if (n == 2) chk("lat_3cyc", dout_valid, 1);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        exp_q = '{16'd0, 16'd4, 16'd8, 16'd12};
        chk_pops("ramp_pop", exp_q);

        // Overflow: 40 samples with consumer stalled
        do_reset();
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 32'(n) << 15, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_drop", drop_cnt, 2);
        for (int j = 0; j < 9; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("ovf_drained", dout_valid, 0);
        exp_q = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd28};
        chk_pops("ovf_pop", exp_q);

        // Full FIFO with push and pop on the same edge
        do_reset();
        for (int n = 0; n < 34; n++) begin
            step(1'b1, 32'(n) << 15, 1'b0, 1'b0);
        end
        chk("full_pre_level", fifo_level, 8);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("full_pp_level", fifo_level, 8);
        chk("full_pp_drop", drop_cnt, 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] d;
            logic [31:0] r;
            r = $urandom();
            if ($urandom_range(0, 2) == 0) begin
                d = r;
            end else begin
                d = {{11{r[20]}}, r[20:0]} << $urandom_range(0, 10);
            end
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset with 5 entries buffered, then phase restart
        do_reset();
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 32'(n) << 15, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_level", fifo_level, 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_level", fifo_level, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        pops.delete();
        step(1'b1, 32'd7 << 15, 1'b1, 1'b0);
        step(1'b1, 32'd1 << 15, 1'b1, 1'b0);
        step(1'b1, 32'd2 << 15, 1'b1, 1'b0);
        step(1'b1, 32'd3 << 15, 1'b1, 1'b0);
        step(1'b1, 32'd9 << 15, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        exp_q = '{16'd7, 16'd9};
        chk_pops("post_rst_pop", exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
- Downstream neighbour of the 41-tap FIR filter; consumes its 32-bit accumulator output.
- Rounds and scales the Q15-weighted sum to 16 bits, saturates, decimates by DECIM, and buffers results in a small FIFO.
- Presents results on a valid/ready stream to the next consumer (DAC formatter / bus bridge).
- Reports saturation and FIFO-drop status.

Parameters:
- IN_W, 32, input sample width (FIR accumulator width)
- OUT_W, 16, output sample width
- SHIFT, 15, right-shift applied after rounding (Q15 coefficients); legal range 1..IN_W-OUT_W
- DECIM, 4, decimation ratio, >=1
- FIFO_DEPTH, 8, output FIFO entries, power of two >=2

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- din  in  IN_W  FIR output sample, two's complement
- din_en  in  1  din is a new sample this cycle
- dout  out  OUT_W  FIFO head sample, two's complement
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accepts dout
- sat_flag  out  1  sticky: a kept sample saturated
- drop_cnt  out  16  count of kept samples lost to a full FIFO; saturates at 0xFFFF
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- stat_clr  in  1  synchronous clear of sat_flag, drop_cnt, peak_abs
- peak_abs  out  OUT_W  peak magnitude (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, FIFO empty, pipeline valids 0, decimation phase 0. Takes effect immediately, including mid-transfer.
- Stage 1 (edge k, din_en=1): s1 = sign-extended din (IN_W+1 bits) + 2^(SHIFT-1); s1_v set.
- Stage 2 (edge k+1):
  - q = s1 >>> SHIFT (arithmetic shift).
  - Clamp q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; set sat when clamped.
  - keep = (phase==0); phase increments modulo DECIM on every s1_v.
  - First sample after reset is kept.
- Stage 3 (edge k+2): kept sample is pushed into the FIFO; dout_valid rises after edge k+2 if the FIFO was empty. Latency: din to dout is 3 cycles.
- sat_flag sets only for kept samples that saturated; it is not set by discarded samples.
- Push when the FIFO is full and no pop occurs in the same cycle: sample discarded, drop_cnt incremented (saturating). sat_flag is still evaluated.
- Simultaneous push and pop at full: both succeed; level unchanged; no drop.
- Simultaneous push and pop at empty: push occurs; dout_valid rises next cycle (no fall-through).
- Pop occurs when dout_valid && dout_ready. dout is stable while dout_valid=1 and dout_ready=0.
- stat_clr concurrent with a set/increment event: the clear wins for that cycle.
- din_en=0 produces no pipeline bubbles beyond gating; phase holds its value.

Optional Feature:
- Macro FIR_OUT_PEAK_EN.
- Defined: peak_abs tracks max |sample| over kept samples, with |-2^(OUT_W-1)| clamped to 2^(OUT_W-1)-1. Updated at stage 3 whether or not the sample is dropped. Cleared by stat_clr or reset.
- Undefined: peak_abs driven constant 0; no peak logic synthesised.

Decomposition:
- Package fir_out_pkg:
  - IN_W/OUT_W defaults
  - OUT_MAX/OUT_MIN constants
  - DROP_CNT_W=16
  - typedef out_sample_t (signed OUT_W)
  - round_sat function (round, shift, clamp, sat bit)
- Sub-module fir_out_fifo: synchronous show-ahead FIFO with async active-low reset, push/pop/full/empty/level.
- Top-level holds the pipeline, decimation counter and status registers.

Test Plan (defaults):
- din_en=1, din=0x00004000, DECIM=1 -> dout=0x0001. din=0x00003FFF -> dout=0x0000. sat_flag stays 0.
- din=0x40000000 -> dout=0x7FFF, sat_flag=1. din=0x80000000 -> dout=0x8000. din=0xC0000000 -> dout=0x8000 with no new saturation; check after stat_clr.
- Ramp din=n<<15 for n=0..15, dout_ready=1 -> outputs 0,4,8,12. First dout_valid appears 3 cycles after n=0.
- dout_ready=0, 40 consecutive samples -> 10 kept, fifo_level=8, drop_cnt=2. Then dout_ready=1 -> 8 pops in order, dout_valid falls.
- FIFO full with dout_ready=1 and a kept push on the same edge -> level stays 8, drop_cnt unchanged.
- reset_n low mid-stream with 5 entries -> dout_valid=0 and fifo_level=0 without a clock edge. After release, the first sample is kept and the counter restarts at phase 0.
